// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier with a start/busy/done handshake.
// Each RUN cycle does one WIDTH-bit add with carry, then shifts {sum, mplier} right by 1.
module seq_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH:0]       acc_q, acc_d;
  logic [WIDTH:0]       sum;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 load;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    load      = 1'b0;
    // acc_q[WIDTH] is always zero after a shift, so this is a WIDTH-bit add with carry-out.
    sum       = acc_q + {1'b0, (mplier_q[0] ? mcand_q : '0)};

    unique case (state_q)
      StIdle: begin
        if (start) load = 1'b1;
      end
      StRun: begin
        acc_d    = {1'b0, sum[WIDTH:1]};
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d   = StDone;
          product_d = {acc_d[WIDTH-1:0], mplier_d};
        end
      end
      StDone: begin
        state_d = StIdle;
        if (start) load = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CntW'(WIDTH);
      state_d  = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == StRun);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed cases plus random operands,
// checked against plain integer multiplication and handshake timing rules.
module tb_seq_multiplier;

  localparam int W = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  logic [31:0] prev_prod = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Handshake invariants, sampled mid-cycle.
  always @(negedge clk) begin
    check("busy_done_excl", {31'b0, busy & done}, 32'd0);
    check("done_single", {31'b0, prev_done & done}, 32'd0);
    if (done) done_cnt++;
    prev_done = done;
  end

  // Issue one multiply; caller is #1 after a posedge. Leaves the bench #1 after the done edge.
  task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [31:0] exp;
    exp   = 32'(x) * 32'(y);
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    check("run_busy_e0", {31'b0, busy}, 32'd1);
    check("prod_hold_e0", 32'(product), prev_prod);
    for (int k = 1; k <= W; k++) begin
      @(posedge clk); #1;
      if (k < W) begin
        check("run_busy", {31'b0, busy}, 32'd1);
      end else begin
        check("done_pulse", {31'b0, done}, 32'd1);
        check("busy_low", {31'b0, busy}, 32'd0);
        check("product", 32'(product), exp);
      end
    end
    prev_prod = exp;
  endtask

  initial begin
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_product", 32'(product), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_mul(4'd3, 4'd5);
    @(posedge clk); #1;
    check("done_drop", {31'b0, done}, 32'd0);

    do_mul(4'd15, 4'd15);
    repeat (10) @(posedge clk);
    #1;
    check("hold_225", 32'(product), 32'd225);

    do_mul(4'd0, 4'd9);
    @(posedge clk); #1;
    do_mul(4'd9, 4'd0);
    @(posedge clk); #1;
    do_mul(4'd3, 4'd5);

    // Start held high: 7x6 then 2x3 back-to-back from DONE.
    @(posedge clk); #1;
    a = 4'd7; b = 4'd6; start = 1'b1;
    @(posedge clk); #1;
    a = 4'd2; b = 4'd3;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    check("held_done1", {31'b0, done}, 32'd1);
    check("held_prod1", 32'(product), 32'd42);
    @(posedge clk); #1;
    check("held_rerun", {31'b0, busy}, 32'd1);
    check("held_keep42", 32'(product), 32'd42);
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    start = 1'b0;
    check("held_done2", {31'b0, done}, 32'd1);
    check("held_prod2", 32'(product), 32'd6);
    prev_prod = 32'd6;

    // Start and operand changes during RUN are ignored.
    @(posedge clk); #1;
    d0 = done_cnt;
    a = 4'd4; b = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 4'd9; b = 4'd13;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("ign_done", {31'b0, done}, 32'd1);
    check("ign_prod", 32'(product), 32'd16);
    repeat (4) @(posedge clk);
    #1;
    check("ign_one_done", 32'(done_cnt - d0), 32'd1);
    prev_prod = 32'd16;

    // Reset in the middle of RUN abandons the operation.
    a = 4'd12; b = 4'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_done", {31'b0, done}, 32'd0);
    check("mrst_prod", 32'(product), 32'd0);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (8) @(posedge clk);
    #1;
    check("mrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("mrst_prod_hold", 32'(product), 32'd0);
    prev_prod = 32'd0;
    do_mul(4'd12, 4'd11);

    // Random operands with random gaps, including back-to-back restarts from DONE.
    for (int i = 0; i < 40; i++) begin
      int gap;
      logic [W-1:0] x;
      logic [W-1:0] y;
      gap = $urandom_range(0, 2);
      x   = W'($urandom);
      y   = W'($urandom);
      repeat (gap) @(posedge clk);
      if (gap != 0) #1;
      do_mul(x, y);
    end
    repeat (3) @(posedge clk);
    #1;
    check("final_prod", 32'(product), prev_prod);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
